// File: rtl/styler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : styler_pkg
// Purpose  : Shared types and constants for the styler scan-out path.
//            CELL_W  - width of one styled character-cell row (pixels)
//            SCAN_W  - width of the scanline index inside a cell
//            fetch_state_e - fetch handshake state
//            tag_t   - start-of-line / start-of-frame markers carried with
//                      each fetched word
// Revision : 1.0 - initial release
// ============================================================================
package styler_pkg;

  localparam int CELL_W = 16;
  localparam int SCAN_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic sol;
    logic sof;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/styler_pixel_shift.sv
`default_nettype none
// ============================================================================
// Module   : styler_pixel_shift
// Purpose  : One-word holding register in front of a 16-bit MSB-first
//            shifter, presenting pixels on a ready/valid stream.
// Ports    : clk, rstN        - clock, asynchronous active-low reset
//            flush_i          - empty both registers
//            load_i           - a fetched word (data_i/tag_i) arrives
//            data_i, tag_i    - fetched word and its SOL/SOF tags
//            pixelReady       - sink accepts the current pixel
//            pixel, pixelSol, pixelSof, pixelValid - output stream
//            hold_full_o      - holding register occupied
//            starve_o         - last bit leaves with nothing to follow
// Revision : 1.0 - initial release
// ============================================================================
module styler_pixel_shift
  import styler_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [CELL_W-1:0] data_i,
  input  tag_t              tag_i,
  input  logic              pixelReady,
  output logic              pixel,
  output logic              pixelSol,
  output logic              pixelSof,
  output logic              pixelValid,
  output logic              hold_full_o,
  output logic              starve_o
);

  localparam int CNT_W = $clog2(CELL_W);

  logic [CELL_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              shift_vld_q, shift_vld_d;
  tag_t              shift_tag_q, shift_tag_d;
  logic [CELL_W-1:0] hold_q, hold_d;
  tag_t              hold_tag_q, hold_tag_d;
  logic              hold_vld_q, hold_vld_d;

  logic w_accept;
  logic w_last;
  logic w_free;
  logic w_direct;

  assign w_accept = shift_vld_q & pixelReady;
  assign w_last   = w_accept & (cnt_q == '0);
  // Shifter can take a new word this cycle: empty, or its last bit is leaving.
  assign w_free   = ~shift_vld_q | w_last;
  // Fetched word bypasses holding only when nothing is queued ahead of it.
  assign w_direct = load_i & w_free & ~hold_vld_q;

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    shift_vld_d = shift_vld_q;
    shift_tag_d = shift_tag_q;
    hold_d      = hold_q;
    hold_tag_d  = hold_tag_q;
    hold_vld_d  = hold_vld_q;

    if (flush_i) begin
      shift_vld_d = 1'b0;
      shift_tag_d = '0;
      hold_vld_d  = 1'b0;
    end else begin
      if (w_free) begin
        if (hold_vld_q) begin
          shift_d     = hold_q;
          shift_tag_d = hold_tag_q;
          cnt_d       = '1;
          shift_vld_d = 1'b1;
          hold_vld_d  = 1'b0;
        end else if (load_i) begin
          shift_d     = data_i;
          shift_tag_d = tag_i;
          cnt_d       = '1;
          shift_vld_d = 1'b1;
        end else begin
          shift_vld_d = 1'b0;
          shift_tag_d = '0;
        end
      end else if (w_accept) begin
        shift_d     = {shift_q[CELL_W-2:0], 1'b0};
        cnt_d       = cnt_q - CNT_W'(1);
        // Tags mark only the leftmost pixel of a word.
        shift_tag_d = '0;
      end

      // Same-cycle holding->shifter transfer and new arrival: the new word
      // refills holding, so nothing is lost.
      if (load_i && !w_direct) begin
        hold_d     = data_i;
        hold_tag_d = tag_i;
        hold_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      shift_vld_q <= 1'b0;
      shift_tag_q <= '0;
      hold_q      <= '0;
      hold_tag_q  <= '0;
      hold_vld_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      shift_vld_q <= shift_vld_d;
      shift_tag_q <= shift_tag_d;
      hold_q      <= hold_d;
      hold_tag_q  <= hold_tag_d;
      hold_vld_q  <= hold_vld_d;
    end
  end

  assign pixelValid  = shift_vld_q;
  assign pixel       = shift_vld_q & shift_q[CELL_W-1];
  assign pixelSol    = shift_vld_q & shift_tag_q.sol;
  assign pixelSof    = shift_vld_q & shift_tag_q.sof;
  assign hold_full_o = hold_vld_q;
  assign starve_o    = w_last & ~hold_vld_q & ~load_i;

endmodule
`default_nettype wire

// File: rtl/styler_scanout.sv
`default_nettype none
// ============================================================================
// Module   : styler_scanout
// Purpose  : Walks character cells (column, scanline, row), fetches one
//            styled 16-bit row per cell and streams it out MSB-first.
//            Also generates the per-frame faint/blink/cursor phases.
// Ports    : clk, rstN     - clock, asynchronous active-low reset
//            run           - 1 = scan, 0 = flush to (0,0,0) and stop
//            fetchReq/fetchAck, fetchCol, fetchRow, scanlineOut,
//            styledBitmap  - cell fetch handshake towards the styler
//            faintPhase, blinkPhase, cursorPhase - frame phases
//            pixel, pixelSol, pixelSof, pixelValid, pixelReady - stream
//            underrun      - sticky: stream ran dry mid-frame while running
// Revision : 1.0 - initial release
// ============================================================================
module styler_scanout
  import styler_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int ROWS       = 25,
  parameter int BLINK_DIV  = 32,
  parameter int CURSOR_DIV = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     run,
  output logic                     fetchReq,
  output logic [$clog2(COLS)-1:0]  fetchCol,
  output logic [$clog2(ROWS)-1:0]  fetchRow,
  output logic [SCAN_W-1:0]        scanlineOut,
  input  logic                     fetchAck,
  input  logic [CELL_W-1:0]        styledBitmap,
  output logic                     faintPhase,
  output logic                     blinkPhase,
  output logic                     cursorPhase,
  output logic                     pixel,
  output logic                     pixelSol,
  output logic                     pixelSof,
  output logic                     pixelValid,
  input  logic                     pixelReady,
  output logic                     underrun
);

  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);
  localparam int BLINK_W  = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
  localparam int CURSOR_W = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;

  localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [CURSOR_W-1:0] CURSOR_LAST = CURSOR_W'(CURSOR_DIV - 1);

  fetch_state_e        state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                faint_q, faint_d;
  logic                blink_q, blink_d;
  logic                cursor_q, cursor_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic [CURSOR_W-1:0] cursor_cnt_q, cursor_cnt_d;
  logic                underrun_q, underrun_d;

  logic w_hold_full;
  logic w_starve;
  logic w_ack;
  logic w_take;
  logic w_pos_zero;
  logic w_frame_wrap;
  tag_t w_tag;

  // Acks that arrive after run dropped complete the handshake but the data
  // is thrown away.
  assign w_ack        = (state_q == REQ) & fetchAck;
  assign w_take       = w_ack & run;
  assign w_pos_zero   = (col_q == '0) & (scan_q == '0) & (row_q == '0);
  assign w_frame_wrap = w_take & (col_q == COL_LAST) & (scan_q == '1) & (row_q == ROW_LAST);
  assign w_tag.sol    = (col_q == '0);
  assign w_tag.sof    = w_pos_zero;

  // Fetch handshake
  always_comb begin
    state_d  = state_q;
    fetchReq = 1'b0;
    case (state_q)
      IDLE: if (run && !w_hold_full) state_d = REQ;
      REQ: begin
        fetchReq = 1'b1;
        if (fetchAck) state_d = IDLE;
      end
    endcase
  end

  // Cell position; frozen while a request is outstanding.
  always_comb begin
    col_d  = col_q;
    scan_d = scan_q;
    row_d  = row_q;
    if (!run && (state_q == IDLE || w_ack)) begin
      col_d  = '0;
      scan_d = '0;
      row_d  = '0;
    end else if (w_take) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (scan_q == '1) begin
          scan_d = '0;
          row_d  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          scan_d = scan_q + SCAN_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Frame phases and underrun flag
  always_comb begin
    faint_d      = faint_q ^ w_frame_wrap;
    blink_d      = blink_q;
    cursor_d     = cursor_q;
    blink_cnt_d  = blink_cnt_q;
    cursor_cnt_d = cursor_cnt_q;
    underrun_d   = underrun_q;

    if (w_frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
      if (cursor_cnt_q == CURSOR_LAST) begin
        cursor_cnt_d = '0;
        cursor_d     = ~cursor_q;
      end else begin
        cursor_cnt_d = cursor_cnt_q + CURSOR_W'(1);
      end
    end

    // Running dry just before a frame start is a normal gap, not an underrun.
    if (!run) begin
      underrun_d = 1'b0;
    end else if (w_starve && !w_pos_zero) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      col_q        <= '0;
      scan_q       <= '0;
      row_q        <= '0;
      faint_q      <= 1'b0;
      blink_q      <= 1'b0;
      cursor_q     <= 1'b0;
      blink_cnt_q  <= '0;
      cursor_cnt_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      scan_q       <= scan_d;
      row_q        <= row_d;
      faint_q      <= faint_d;
      blink_q      <= blink_d;
      cursor_q     <= cursor_d;
      blink_cnt_q  <= blink_cnt_d;
      cursor_cnt_q <= cursor_cnt_d;
      underrun_q   <= underrun_d;
    end
  end

  assign fetchCol    = col_q;
  assign fetchRow    = row_q;
  assign scanlineOut = scan_q;
  assign faintPhase  = faint_q;
  assign blinkPhase  = blink_q;
  assign cursorPhase = cursor_q;
  assign underrun    = underrun_q;

  styler_pixel_shift u_shift (
    .clk         (clk),
    .rstN        (rstN),
    .flush_i     (~run),
    .load_i      (w_take),
    .data_i      (styledBitmap),
    .tag_i       (w_tag),
    .pixelReady  (pixelReady),
    .pixel       (pixel),
    .pixelSol    (pixelSol),
    .pixelSof    (pixelSof),
    .pixelValid  (pixelValid),
    .hold_full_o (w_hold_full),
    .starve_o    (w_starve)
  );

endmodule
`default_nettype wire

// File: tb/tb_styler_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_styler_scanout
// Purpose  : Self-checking bench for styler_scanout (COLS=2, ROWS=2,
//            BLINK_DIV=2, CURSOR_DIV=4). Fetched words are expanded into a
//            pixel scoreboard; fetch positions and frame phases are compared
//            against a bench-side position model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_styler_scanout;

  localparam int B_COLS   = 2;
  localparam int B_ROWS   = 2;
  localparam int B_BLINK  = 2;
  localparam int B_CURSOR = 4;

  typedef struct packed {
    logic pix;
    logic sol;
    logic sof;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rstN = 1'b0;
  logic                      run = 1'b0;
  logic                      fetchAck = 1'b0;
  logic                      pixelReady = 1'b0;
  logic [15:0]               styledBitmap = '0;
  logic                      fetchReq;
  logic [$clog2(B_COLS)-1:0] fetchCol;
  logic [$clog2(B_ROWS)-1:0] fetchRow;
  logic [3:0]                scanlineOut;
  logic                      faintPhase, blinkPhase, cursorPhase;
  logic                      pixel, pixelSol, pixelSof, pixelValid, underrun;

  // Stimulus knobs (written by main, read by the engine)
  int ack_delay   = 3;
  bit ack_en      = 1'b1;
  bit ready_knob  = 1'b1;
  bit expect_cont = 1'b0;
  bit first_word  = 1'b1;

  // Position model and scoreboard
  int   m_col = 0, m_scan = 0, m_row = 0, m_frames = 0, n_acks = 0;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  styler_scanout #(
    .COLS(B_COLS), .ROWS(B_ROWS), .BLINK_DIV(B_BLINK), .CURSOR_DIV(B_CURSOR)
  ) dut (
    .clk(clk), .rstN(rstN), .run(run),
    .fetchReq(fetchReq), .fetchCol(fetchCol), .fetchRow(fetchRow),
    .scanlineOut(scanlineOut), .fetchAck(fetchAck), .styledBitmap(styledBitmap),
    .faintPhase(faintPhase), .blinkPhase(blinkPhase), .cursorPhase(cursorPhase),
    .pixel(pixel), .pixelSol(pixelSol), .pixelSof(pixelSof),
    .pixelValid(pixelValid), .pixelReady(pixelReady), .underrun(underrun)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_fetchReq"}, fetchReq, 0);
    check_eq({pfx, "_pixelValid"}, pixelValid, 0);
    check_eq({pfx, "_pixel"}, pixel, 0);
    check_eq({pfx, "_sol"}, pixelSol, 0);
    check_eq({pfx, "_sof"}, pixelSof, 0);
    check_eq({pfx, "_underrun"}, underrun, 0);
    check_eq({pfx, "_faint"}, faintPhase, 0);
    check_eq({pfx, "_blink"}, blinkPhase, 0);
    check_eq({pfx, "_cursor"}, cursorPhase, 0);
  endtask

  // Engine: on each falling edge, monitor the stream and respond to fetches.
  initial begin : engine
    bit          stall_pend;
    logic        stall_pix;
    int          req_age;
    exp_t        e;
    logic [15:0] d;
    stall_pend = 1'b0;
    stall_pix  = 1'b0;
    req_age    = 0;
    forever begin
      @(negedge clk);
      if (rstN) begin
        check_eq("faint_phase", faintPhase, m_frames % 2);
        check_eq("blink_phase", blinkPhase, (m_frames / B_BLINK) % 2);
        check_eq("cursor_phase", cursorPhase, (m_frames / B_CURSOR) % 2);
        if (stall_pend) begin
          check_eq("stall_valid", pixelValid, 1);
          check_eq("stall_pixel", pixel, stall_pix);
        end
        if (expect_cont) check_eq("continuous_valid", pixelValid, 1);
        if (pixelValid && pixelReady) begin
          check_eq("pixel_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check_eq("pixel", pixel, e.pix);
            check_eq("pixel_sol", pixelSol, e.sol);
            check_eq("pixel_sof", pixelSof, e.sof);
          end
        end
        stall_pend = pixelValid && !pixelReady;
        stall_pix  = pixel;
      end else begin
        stall_pend = 1'b0;
      end

      fetchAck = 1'b0;
      if (rstN && fetchReq) begin
        check_eq("fetch_col", fetchCol, m_col);
        check_eq("fetch_scan", scanlineOut, m_scan);
        check_eq("fetch_row", fetchRow, m_row);
        if (ack_en && req_age >= ack_delay) begin
          fetchAck = 1'b1;
          req_age  = 0;
          if (run) begin
            d = first_word ? 16'hA5C3 : 16'($urandom);
            first_word   = 1'b0;
            styledBitmap = d;
            for (int b = 15; b >= 0; b--) begin
              e.pix = d[b];
              e.sol = (b == 15) && (m_col == 0);
              e.sof = (b == 15) && (m_col == 0) && (m_scan == 0) && (m_row == 0);
              q.push_back(e);
            end
            n_acks++;
            if (m_col == B_COLS - 1) begin
              m_col = 0;
              if (m_scan == 15) begin
                m_scan = 0;
                if (m_row == B_ROWS - 1) begin
                  m_row = 0;
                  m_frames++;
                end else m_row++;
              end else m_scan++;
            end else m_col++;
          end else begin
            styledBitmap = 16'hFFFF;
            m_col  = 0;
            m_scan = 0;
            m_row  = 0;
          end
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
      pixelReady = ready_knob;
    end
  end

  initial begin : main
    rstN = 1'b0;
    run  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    check_eq("reset_col", fetchCol, 0);
    check_eq("reset_scan", scanlineOut, 0);
    check_eq("reset_row", fetchRow, 0);
    rstN = 1'b1;
    tick();

    // First word: request follows run by one cycle, A5C3 streams with tags.
    run = 1'b1;
    check_eq("req_before_run", fetchReq, 0);
    tick();
    check_eq("req_after_run", fetchReq, 1);
    for (int i = 0; i < 50 && !pixelValid; i++) tick();
    check_eq("first_valid", pixelValid, 1);
    check_eq("first_pixel", pixel, 1);
    check_eq("first_sol", pixelSol, 1);
    check_eq("first_sof", pixelSof, 1);

    // Back-to-back words with immediate ack; frame phases over several frames.
    expect_cont = 1'b1;
    ack_delay   = 0;
    for (int i = 0; i < 6000 && n_acks < 128; i++) tick();
    check_eq("acks_128", n_acks, 128);
    check_eq("faint_at_128", faintPhase, 0);
    check_eq("blink_at_128", blinkPhase, 1);
    check_eq("cursor_at_128", cursorPhase, 0);
    for (int i = 0; i < 6000 && n_acks < 256; i++) tick();
    check_eq("acks_256", n_acks, 256);
    check_eq("blink_at_256", blinkPhase, 0);
    check_eq("cursor_at_256", cursorPhase, 1);
    check_eq("no_underrun_streaming", underrun, 0);

    // Sink stall: stream frozen, one extra word buffered, no further fetch.
    ready_knob = 1'b0;
    repeat (20) tick();
    check_eq("stall_no_fetch", fetchReq, 0);
    check_eq("stall_still_valid", pixelValid, 1);
    check_eq("stall_buffered", q.size() > 16, 1);
    check_eq("stall_no_underrun", underrun, 0);
    ready_knob = 1'b1;
    tick();

    // Withhold acks away from a frame start: underrun must latch.
    expect_cont = 1'b0;
    for (int i = 0; i < 200 && (m_col | m_scan | m_row) == 0; i++) tick();
    ack_en = 1'b0;
    repeat (40) tick();
    check_eq("underrun_set", underrun, 1);
    check_eq("dry_valid", pixelValid, 0);
    check_eq("dry_req", fetchReq, 1);
    check_eq("dry_queue_empty", q.size(), 0);

    // Stop while a request is outstanding; ack later is discarded.
    run = 1'b0;
    tick();
    check_eq("underrun_clear", underrun, 0);
    check_eq("req_held_stop", fetchReq, 1);
    repeat (4) begin
      tick();
      check_eq("req_held", fetchReq, 1);
    end
    ack_en = 1'b1;
    tick();
    check_eq("req_dropped", fetchReq, 0);
    check_eq("stop_valid", pixelValid, 0);
    check_eq("stop_col", fetchCol, 0);
    check_eq("stop_scan", scanlineOut, 0);
    check_eq("stop_row", fetchRow, 0);
    tick();
    check_eq("idle_stopped", fetchReq, 0);
    check_eq("idle_valid", pixelValid, 0);

    // Restart from (0,0,0), then reset in the middle of a word.
    run = 1'b1;
    repeat (30) tick();
    check_eq("restart_valid", pixelValid, 1);
    rstN = 1'b0;
    #1;
    check_all_zero("async_reset");
    q.delete();
    m_col    = 0;
    m_scan   = 0;
    m_row    = 0;
    m_frames = 0;
    run      = 1'b0;
    tick();
    rstN = 1'b1;
    repeat (2) tick();
    check_eq("post_reset_req", fetchReq, 0);
    check_eq("post_reset_valid", pixelValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
